// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the serial link receive path.
//   - state_t            : receiver FSM states
//   - SERIAL_DATA_BITS   : data bits per frame (LSB first on the wire)
//   - SERIAL_IDLE_LEVEL  : line level when no frame is in flight
package serial_pkg;

    localparam int   SERIAL_DATA_BITS  = 8;
    localparam logic SERIAL_IDLE_LEVEL = 1'b1;

    // PARITY is only reachable when SERIAL_RX_PARITY_EN is defined; the
    // encoding is kept in both builds so debug views decode identically.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

endpackage

// File: rtl/bit_sync.sv
// bit_sync
//   Two-flop synchronizer for a single asynchronous input. Both flops reset
//   to the idle line level so a reset never looks like a start bit.
//   Ports:
//     clk - system clock, falling-edge active
//     rst - asynchronous active-high reset
//     d   - asynchronous input
//     q   - synchronized output (two falling edges of latency)
module bit_sync
    import serial_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            meta <= SERIAL_IDLE_LEVEL;
            q    <= SERIAL_IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receives start / 8 data bits (LSB first) / optional even parity / stop
//   frames on rxd and holds each good byte for the host.
//   Optional feature macro: SERIAL_RX_PARITY_EN (adds the parity bit and the
//   PARITY state; parity_err is tied 0 when the macro is undefined).
//   Ports:
//     clk        - system clock; all state changes on the falling edge
//     rst        - asynchronous active-high reset
//     rxd        - serial line, idle high, asynchronous to clk
//     rd         - read strobe, acknowledges the held byte
//     data_out   - last good byte received
//     valid      - a byte is held and unread
//     busy       - a frame is in progress (registered copy of state != IDLE)
//     frame_err  - one-cycle pulse, stop bit sampled low
//     overrun    - one-cycle pulse, good frame landed on an unread byte
//     parity_err - one-cycle pulse, parity mismatch
//     state_dbg  - current FSM state encoding (serial_pkg::state_t)
//
//   Host handshake: valid rises when a good byte is loaded and stays high
//   until the host asserts rd for a cycle; rd while valid is low is ignored,
//   and a load on the same edge as rd wins (valid stays high, no overrun).
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic [2:0] state_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1    = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_DBIT = 3'(SERIAL_DATA_BITS - 1);

    logic rxs;

    bit_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt, cnt_nxt;
    logic [2:0]                  dcnt, dcnt_nxt;
    logic [SERIAL_DATA_BITS-1:0] shreg, shreg_nxt;
    // Frame outcome, registered on the stop-sample edge and applied to the
    // host outputs one edge later.
    logic                        done_good, good_nxt;
    logic                        done_ferr, ferr_nxt;
    logic                        bit_end;
    logic                        parity_ok;

`ifdef SERIAL_RX_PARITY_EN
    logic par_bit, par_nxt;
    logic done_perr, perr_nxt;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_ok = ~(^{shreg, par_bit});
`else
    assign parity_ok = 1'b1;
`endif

    // Mid-bit sample point once the start-bit half period has been consumed.
    assign bit_end   = (cnt == BIT_M1);
    assign state_dbg = state;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            shreg     <= '0;
            done_good <= 1'b0;
            done_ferr <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit   <= 1'b0;
            done_perr <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dcnt      <= dcnt_nxt;
            shreg     <= shreg_nxt;
            done_good <= good_nxt;
            done_ferr <= ferr_nxt;
`ifdef SERIAL_RX_PARITY_EN
            par_bit   <= par_nxt;
            done_perr <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dcnt_nxt  = dcnt;
        shreg_nxt = shreg;
        good_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_nxt   = par_bit;
        perr_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                dcnt_nxt = '0;
                if (rxs != SERIAL_IDLE_LEVEL) begin
                    state_nxt = START;
                end
            end
            START: begin
                // Re-check the line at the middle of the start bit; a high
                // level there means it was a glitch.
                if (cnt == HALF_M1) begin
                    cnt_nxt   = '0;
                    state_nxt = (rxs == SERIAL_IDLE_LEVEL) ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    shreg_nxt = {rxs, shreg[SERIAL_DATA_BITS-1:1]};
                    dcnt_nxt  = dcnt + 3'd1;
                    if (dcnt == LAST_DBIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    par_nxt   = rxs;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
`ifdef SERIAL_RX_PARITY_EN
                    perr_nxt = ~parity_ok;
`endif
                    if (rxs == SERIAL_IDLE_LEVEL) begin
                        good_nxt  = parity_ok;
                        state_nxt = IDLE;
                    end else begin
                        // Line held low past the stop bit (break or noise):
                        // wait for it to return high before hunting again.
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rxs == SERIAL_IDLE_LEVEL) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                dcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= 8'h00;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            busy      <= (state != IDLE);
            frame_err <= done_ferr;
            overrun   <= 1'b0;
            if (done_good) begin
                data_out <= shreg;
                valid    <= 1'b1;
                // A read on the load edge consumed the old byte in time.
                overrun  <= valid & ~rd;
            end else if (rd) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= done_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
//   Directed bench for serial_frame_rx with CLKS_PER_BIT = 8. Frames are
//   driven bit by bit; each frame pushes its expected outcome (load edge,
//   data, valid, flags) to a queue that a monitor pops on the load edge.
//   Define SERIAL_RX_PARITY_EN for both RTL and bench to cover parity.
module tb_serial_frame_rx;
    import serial_pkg::*;

    localparam int C = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NBITS = 10;  // data + parity + stop, after the start bit
`else
    localparam int NBITS = 9;   // data + stop, after the start bit
`endif

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       rd;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic [2:0] state_dbg;

    serial_frame_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rd         (rd),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Index of the most recent falling (active) edge.
    int neg_cnt = 0;
    always @(negedge clk) neg_cnt <= neg_cnt + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        int         t;
        logic [7:0] data;
        logic       valid;
        logic       valid_pre;
        logic       ferr;
        logic       perr;
        logic       ovr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_data   = 8'h00;
    logic       m_valid  = 1'b0;
    logic [7:0] pbits;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) begin
        if (exp_q.size() > 0 && neg_cnt == exp_q[0].t - 1) begin
            check("valid_before_load", 8'(valid), 8'(exp_q[0].valid_pre));
        end
        if (exp_q.size() > 0 && neg_cnt == exp_q[0].t) begin
            mon_e = exp_q.pop_front();
            check("load_data_out",   data_out,        mon_e.data);
            check("load_valid",      8'(valid),       8'(mon_e.valid));
            check("load_frame_err",  8'(frame_err),   8'(mon_e.ferr));
            check("load_parity_err", 8'(parity_err),  8'(mon_e.perr));
            check("load_overrun",    8'(overrun),     8'(mon_e.ovr));
        end else begin
            check("no_stray_flag", {5'd0, frame_err, parity_err, overrun}, 8'd0);
        end
    end

    // ---------------- driver tasks ----------------
    // Drives one frame starting at a rising edge; returns on the rising edge
    // right after the outcome edge. rd_at_load raises rd for that edge.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_bad, input logic rd_at_load);
        exp_t             e;
        logic [NBITS-1:0] bits;
        int               t0;
        t0          = neg_cnt + 1;
        e.t         = t0 + 3 + C / 2 + NBITS * C;
        e.valid_pre = m_valid;
        e.ferr      = ~stop;
        e.perr      = par_bad;
        e.ovr       = 1'b0;
        if (stop && !par_bad) begin
            e.ovr   = m_valid & ~rd_at_load;
            m_data  = d;
            m_valid = 1'b1;
        end
        e.data  = m_data;
        e.valid = m_valid;
        exp_q.push_back(e);
`ifdef SERIAL_RX_PARITY_EN
        bits = {stop, (^d) ^ par_bad, d};
`else
        bits = {stop, d};
`endif
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        check("busy_before_rise", 8'(busy), 8'd0);
        @(posedge clk);
        check("busy_rise", 8'(busy), 8'd1);
        repeat (C - 4) @(posedge clk);
        for (int i = 0; i < NBITS; i++) begin
            rxd = bits[i];
            if (i == NBITS - 1) begin
                repeat (C - 1) @(posedge clk);
                rd = rd_at_load;
                @(posedge clk);
                rd = 1'b0;
            end else begin
                repeat (C) @(posedge clk);
            end
        end
    endtask

    task automatic read_byte();
        rd = 1'b1;
        @(posedge clk);
        rd = 1'b0;
        m_valid = 1'b0;
        check("rd_clears_valid", 8'(valid), 8'd0);
        check("rd_keeps_data", data_out, m_data);
    endtask

    task automatic recover_high();
        repeat (2 * C) @(posedge clk);
        check("busy_while_low", 8'(busy), 8'd1);
        rxd = 1'b1;
        repeat (6) @(posedge clk);
        check("busy_after_high", 8'(busy), 8'd0);
        repeat (C) @(posedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        rd  = 1'b0;

        // Reset defaults, held.
        repeat (3) @(posedge clk);
        check("rst_data_out",   data_out,       8'h00);
        check("rst_valid",      8'(valid),      8'd0);
        check("rst_busy",       8'(busy),       8'd0);
        check("rst_frame_err",  8'(frame_err),  8'd0);
        check("rst_overrun",    8'(overrun),    8'd0);
        check("rst_parity_err", 8'(parity_err), 8'd0);
        check("rst_state",      8'(state_dbg),  8'(IDLE));
        repeat (50) @(posedge clk);
        check("rst_hold_data", data_out,   8'h00);
        check("rst_hold_valid", 8'(valid), 8'd0);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        check("idle_valid", 8'(valid), 8'd0);
        check("idle_busy",  8'(busy),  8'd0);

        // Single frame then read.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        read_byte();
        repeat (C) @(posedge clk);

        // Glitch rejection.
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        check("glitch_busy_up", 8'(busy), 8'd1);
        repeat (10) @(posedge clk);
        check("glitch_busy_down", 8'(busy),      8'd0);
        check("glitch_valid",     8'(valid),     8'd0);
        check("glitch_state",     8'(state_dbg), 8'(IDLE));

        // Frame error: stop bit low, line held low afterwards.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        recover_high();

        // Overrun, then simultaneous read on the load edge.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        read_byte();
        repeat (C) @(posedge clk);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0, 1'b1);
        repeat (C) @(posedge clk);
        check("rd_on_load_valid", 8'(valid), 8'd1);

`ifdef SERIAL_RX_PARITY_EN
        read_byte();
        repeat (C) @(posedge clk);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        read_byte();
        repeat (C) @(posedge clk);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (C) @(posedge clk);
        check("parity_bad_valid", 8'(valid), 8'd0);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        recover_high();
`endif

        // Reset mid-frame, during data bit 4, with a byte held.
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        repeat (C) @(posedge clk);
        pbits = 8'h5A;
        rxd = 1'b0;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = pbits[i];
            repeat (C) @(posedge clk);
        end
        rxd = pbits[4];
        repeat (C / 2) @(posedge clk);
        check("pre_abort_busy", 8'(busy), 8'd1);
        rst = 1'b1;
        #1;
        check("abort_data_out", data_out,      8'h00);
        check("abort_valid",    8'(valid),     8'd0);
        check("abort_busy",     8'(busy),      8'd0);
        check("abort_state",    8'(state_dbg), 8'(IDLE));
        m_data  = 8'h00;
        m_valid = 1'b0;
        @(posedge clk);
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        repeat (2 * C) @(posedge clk);
        check("post_abort_valid", 8'(valid), 8'd0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);

        // Every queued outcome must have been consumed by now.
        repeat (2 * C) @(posedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Asynchronous serial frame receiver. It is the reading end of the team's shift-register serial link: it takes a single-wire stream (start bit, 8 data bits LSB first, optional parity, stop bit) and presents each byte in parallel to the host logic. The byte is held until a read strobe releases it. The block sits between the off-board `rxd` pin and the lab's register/display logic, alongside the flip-flop based storage cells.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Minimum 4; must be even.
- `clk`  in  1  system clock; all state changes on the falling edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  serial line, idle high; asynchronous to `clk`.
- `rd`  in  1  read strobe; acknowledges the held byte.
- `data_out`  out  8  last good byte received.
- `valid`  out  1  a byte is held and unread.
- `busy`  out  1  a frame is in progress (not IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a good frame completed while `valid` was already 1.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 without the macro.

## Operation
- `rxd` passes through a 2-flop synchronizer. All logic uses the synchronized value `rxs`.
- States and transitions:
  - IDLE → START when `rxs` = 0.
  - START → DATA when the bit counter reaches `CLKS_PER_BIT/2 - 1` and `rxs` = 0.
  - START → IDLE when the bit counter reaches `CLKS_PER_BIT/2 - 1` and `rxs` = 1 (glitch rejected, no flags).
  - DATA → PARITY (macro) or STOP after 8 mid-bit samples, one every `CLKS_PER_BIT` cycles, shifted in LSB first.
  - PARITY → STOP after 1 sample.
  - STOP → IDLE when the stop sample is 1.
  - STOP → WAIT_HIGH when the stop sample is 0.
  - WAIT_HIGH → IDLE once `rxs` = 1.
- Good frame (stop = 1, parity OK):
  - `data_out` loads the shift register.
  - `valid` is set to 1.
  - If `valid` was already 1, `overrun` pulses and the data is overwritten.
- Bad stop: `frame_err` pulses. `data_out` and `valid` are unchanged.
- Bad parity: `parity_err` pulses. `data_out` and `valid` are unchanged. If the stop bit is also bad, both flags pulse together.
- `rd` = 1 clears `valid` on the next edge.
- `rd` on the same edge as a good-frame load: the load wins, `valid` = 1, and no `overrun` pulses.
- `rd` while `valid` = 0 has no effect.
- Reset values: `data_out` = 8'h00; `valid`, `busy`, `frame_err`, `overrun`, `parity_err` = 0; state IDLE; counters 0; synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately. No flag pulses. The receiver restarts on the next falling `rxs` after release.

## Timing
- Bit counter width is `$clog2(CLKS_PER_BIT)`; it wraps to 0 at `CLKS_PER_BIT - 1`.
- Data bit counter is 3 bits; the final sample is at count 7.
- Define t0 as the first clock edge at which the synchronizer input samples `rxd` = 0.
  - `busy` rises at t0+3.
  - Data bit k is sampled at t0 + 2 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - Stop is sampled at t0 + 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`, plus `CLKS_PER_BIT` with parity.
- `valid` and the error pulses assert on the edge after the stop sample.
- `busy` falls on that same edge, unless the next state is WAIT_HIGH.
- A new start bit is accepted the cycle after IDLE is re-entered. Back-to-back frames with a 1-bit stop are received without loss.

## Configuration
- `SERIAL_RX_PARITY_EN`
  - Defined: the frame carries an even-parity bit after bit 7, and the PARITY state is present. Parity check: XOR of the 8 data bits and the parity bit must be 0. `parity_err` is live.
  - Undefined: no PARITY state; frames are 10 bits; `parity_err` is constant 0.

## Structure
- Package `serial_pkg` holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - `SERIAL_DATA_BITS` = 8;
  - `SERIAL_IDLE_LEVEL` = 1'b1.
- Sub-module `bit_sync`: a 2-flop synchronizer with async `rst`, reset value 1, falling-edge clock.
- Everything else is in `serial_frame_rx`.

## Test plan
Directed scenarios, with `CLKS_PER_BIT` = 8:
- **Reset defaults:** assert `rst`, drive `rxd` = 1 → all outputs 0, `data_out` = 8'h00; hold for 50 cycles with no change.
- **Single frame:** send 0xA5 with a good stop bit → `data_out` = 8'hA5 and `valid` = 1 at the exact cycle from Timing; then `rd` for 1 cycle → `valid` = 0 on the next edge.
- **Glitch rejection:** a 3-cycle low pulse on `rxd` → `busy` returns to 0, `valid` stays 0, no flags.
- **Frame error:** send 0x3C with stop bit = 0 → `frame_err` pulses for 1 cycle, `data_out` unchanged, `busy` = 1 until `rxd` returns high.
- **Overrun and simultaneous read:**
  - Send 0x11 then 0x22 with no `rd` → `overrun` pulses on the second frame, `data_out` = 8'h22.
  - Repeat with `rd` on the load edge → no `overrun` pulse.
- **Parity, with the macro defined:**
  - 0x07 with parity bit 1 → accepted.
  - 0x07 with parity bit 0 → `parity_err` pulses, `valid` stays 0.
- **Reset mid-frame:** assert `rst` during bit 4 → all outputs 0 immediately; the next full frame 0x5A is received correctly.
